mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous 4K-word memory (1-cycle registered read) between the instruction-fetch port (IF) and the load/store port (ME) of the pipelined processor.
- Issues at most one access per cycle. ME has fixed priority, and an anti-starvation counter guarantees IF forward progress.
- Returns read data with a per-port valid pulse. The pipeline uses the grant signals to stall.

Parameters:
- ADDR_W, 12, word address width (memory depth 2^ADDR_W words)
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive IF denials after which IF is forced to win one cycle (legal range 1..15)

Ports:
- w_clk  input  1  clock, all state updates on posedge
- w_rst_n  input  1  asynchronous reset, active low
- w_if_req  input  1  IF read request
- w_if_addr  input  ADDR_W  IF word address
- w_if_gnt  output  1  IF access issued this cycle (combinational)
- w_if_rvalid  output  1  IF read data valid (registered)
- w_if_rdata  output  DATA_W  IF read data
- w_me_req  input  1  ME request
- w_me_we  input  1  ME write enable (1 = store, 0 = load)
- w_me_addr  input  ADDR_W  ME word address
- w_me_wdata  input  DATA_W  ME store data
- w_me_gnt  output  1  ME access issued this cycle (combinational)
- w_me_rvalid  output  1  ME load data valid (registered)
- w_me_rdata  output  DATA_W  ME load data
- w_mem_addr  output  ADDR_W  memory address
- w_mem_we  output  1  memory write enable
- w_mem_din  output  DATA_W  memory write data
- w_mem_dout  input  DATA_W  memory read data, valid one cycle after address

Behaviour:
- Reset (w_rst_n low, asynchronous): starve counter=0; pending-owner register=NONE; w_if_rvalid=0; w_me_rvalid=0. Grants are combinational and follow their equations during reset, but no rvalid is produced for any access issued while reset is asserted. A read in flight when reset asserts is dropped; its rvalid never appears.
- Grant decision, combinational each cycle:
  - force_if = w_if_req & (starve_cnt == STARVE_MAX)
  - w_me_gnt = w_me_req & ~force_if
  - w_if_gnt = w_if_req & ~w_me_gnt
  - At most one grant is high per cycle. With no requests, both grants are 0, w_mem_we=0 and w_mem_addr=w_if_addr.
- Memory mux:
  - If w_me_gnt: addr=w_me_addr, we=w_me_we, din=w_me_wdata.
  - Otherwise: addr=w_if_addr, we=0, din=0.
  - w_mem_we is never high without w_me_gnt.
- Starve counter, on posedge:
  - w_if_req & ~w_if_gnt: increment, saturating at STARVE_MAX.
  - w_if_gnt or ~w_if_req: clear to 0.
- Read return, one-cycle latency:
  - Owner register latches IF if w_if_gnt, ME if (w_me_gnt & ~w_me_we), else NONE.
  - Next cycle: w_if_rvalid=(owner==IF), w_me_rvalid=(owner==ME).
  - w_if_rdata and w_me_rdata are both driven from w_mem_dout and are meaningful only while their rvalid is high.
  - Stores produce no rvalid.
- Back-to-back reads to either port are supported every cycle (fully pipelined). No internal buffering: the requester holds req/addr until its grant.
- Read-after-write to the same address in consecutive cycles returns the new data; this is a memory property and the arbiter does not bypass.
- Simultaneous ME store and IF fetch: ME wins unless force_if is active; the IF address is still presented next cycle by the requester.
- ME request during force_if: ME is denied exactly one cycle; the counter then clears and ME regains priority.

Test Plan:
- Reset mid-read: IF read addr 0x010 granted, w_rst_n low before the next posedge -> w_if_rvalid stays 0; after release, counter=0 and both rvalid=0.
- IF only: req every cycle, addrs 0,1,2 holding 0x00000013,0x00100093,0x00200113 -> gnt high every cycle; rvalid on cycles 1-3 with those data in order.
- Contention: IF and ME load (addr 0x100=0xDEADBEEF) both held -> ME granted; w_me_rvalid with 0xDEADBEEF next cycle; w_if_gnt=0.
- Starvation (STARVE_MAX=4): ME req held continuously, IF req held -> ME granted 4 cycles, IF granted on the 5th, ME on the 6th; the pattern repeats with period 5.
- Store then load: ME write 0x12345678 to 0x200, then ME read 0x200 -> no rvalid for the store; load rvalid with 0x12345678; w_mem_we high for exactly 1 cycle.
- No request: both req=0 for 3 cycles -> grants, w_mem_we and rvalids all 0; counter stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory (1-cycle registered read) between
// the instruction-fetch port (IF) and the load/store port (ME). ME has fixed
// priority; a saturating starve counter forces one IF grant after STARVE_MAX
// consecutive IF denials so fetch always makes forward progress.
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_if_req,
  input  logic [ADDR_W-1:0] w_if_addr,
  output logic              w_if_gnt,
  output logic              w_if_rvalid,
  output logic [DATA_W-1:0] w_if_rdata,
  input  logic              w_me_req,
  input  logic              w_me_we,
  input  logic [ADDR_W-1:0] w_me_addr,
  input  logic [DATA_W-1:0] w_me_wdata,
  output logic              w_me_gnt,
  output logic              w_me_rvalid,
  output logic [DATA_W-1:0] w_me_rdata,
  output logic [ADDR_W-1:0] w_mem_addr,
  output logic              w_mem_we,
  output logic [DATA_W-1:0] w_mem_din,
  input  logic [DATA_W-1:0] w_mem_dout
);

  // Counter is 4 bits wide: STARVE_MAX is limited to 1..15.
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Owner of the read currently returning from memory.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_ME   = 2'd2;

  logic [3:0] starve_cnt_r;
  logic [3:0] starve_cnt_nxt_s;
  logic [1:0] owner_r;
  logic [1:0] owner_nxt_s;
  logic       force_if_s;
  logic       me_gnt_s;
  logic       if_gnt_s;

  // Grant decision: ME wins unless IF has been starved STARVE_MAX cycles.
  always_comb begin
    force_if_s = w_if_req & (starve_cnt_r == STARVE_LIM);
    me_gnt_s   = w_me_req & ~force_if_s;
    if_gnt_s   = w_if_req & ~me_gnt_s;
  end

  // Memory port mux: ME drives the port only when granted, else IF address.
  always_comb begin
    if (me_gnt_s) begin
      w_mem_addr = w_me_addr;
      w_mem_we   = w_me_we;
      w_mem_din  = w_me_wdata;
    end else begin
      w_mem_addr = w_if_addr;
      w_mem_we   = 1'b0;
      w_mem_din  = {DATA_W{1'b0}};
    end
  end

  // Next-state for the starve counter and the read-owner register.
  always_comb begin
    starve_cnt_nxt_s = 4'd0;
    if (w_if_req & ~if_gnt_s) begin
      if (starve_cnt_r == STARVE_LIM) begin
        starve_cnt_nxt_s = STARVE_LIM;
      end else begin
        starve_cnt_nxt_s = starve_cnt_r + 4'd1;
      end
    end else begin
      starve_cnt_nxt_s = 4'd0;
    end

    owner_nxt_s = OWN_NONE;
    case ({if_gnt_s, me_gnt_s & ~w_me_we})
      2'b10:   owner_nxt_s = OWN_IF;
      2'b01:   owner_nxt_s = OWN_ME;
      default: owner_nxt_s = OWN_NONE;
    endcase
  end

  // State registers; reset drops any read in flight.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      starve_cnt_r <= 4'd0;
      owner_r      <= OWN_NONE;
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
      owner_r      <= owner_nxt_s;
    end
  end

  assign w_if_gnt    = if_gnt_s;
  assign w_me_gnt    = me_gnt_s;
  assign w_if_rvalid = (owner_r == OWN_IF);
  assign w_me_rvalid = (owner_r == OWN_ME);
  assign w_if_rdata  = w_mem_dout;
  assign w_me_rdata  = w_mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural
// single-port memory (registered read, write-then-read-new-data).
module tb_mem_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              w_clk;
  logic              w_rst_n;
  logic              w_if_req;
  logic [ADDR_W-1:0] w_if_addr;
  logic              w_if_gnt;
  logic              w_if_rvalid;
  logic [DATA_W-1:0] w_if_rdata;
  logic              w_me_req;
  logic              w_me_we;
  logic [ADDR_W-1:0] w_me_addr;
  logic [DATA_W-1:0] w_me_wdata;
  logic              w_me_gnt;
  logic              w_me_rvalid;
  logic [DATA_W-1:0] w_me_rdata;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_din;
  logic [DATA_W-1:0] w_mem_dout;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .w_if_req   (w_if_req),
    .w_if_addr  (w_if_addr),
    .w_if_gnt   (w_if_gnt),
    .w_if_rvalid(w_if_rvalid),
    .w_if_rdata (w_if_rdata),
    .w_me_req   (w_me_req),
    .w_me_we    (w_me_we),
    .w_me_addr  (w_me_addr),
    .w_me_wdata (w_me_wdata),
    .w_me_gnt   (w_me_gnt),
    .w_me_rvalid(w_me_rvalid),
    .w_me_rdata (w_me_rdata),
    .w_mem_addr (w_mem_addr),
    .w_mem_we   (w_mem_we),
    .w_mem_din  (w_mem_din),
    .w_mem_dout (w_mem_dout)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Behavioural synchronous memory: one-cycle registered read.
  always @(posedge w_clk) begin
    if (w_mem_we) mem[w_mem_addr] <= w_mem_din;
    w_mem_dout <= mem[w_mem_addr];
  end

  task automatic test_reset();
    // During reset grants follow their equations but no rvalid is produced.
    @(negedge w_clk);
    w_if_req = 1'b1; w_if_addr = 12'h010;
    #1;
    n_checks++; if (w_if_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_gnt: got %b expected 1", w_if_gnt); end
    n_checks++; if (w_if_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid0: got %b expected 0", w_if_rvalid); end
    @(negedge w_clk); #1;
    n_checks++; if (w_if_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid1: got %b expected 0", w_if_rvalid); end
    // Release; the next posedge issues a normal read.
    w_rst_n = 1'b1;
    @(negedge w_clk); #1;
    n_checks++; if (w_if_rvalid !== 1'b1 || w_if_rdata !== 32'hCAFE0010) begin n_fail++; $display("FAIL rst_normal_read: got %b/%h expected 1/cafe0010", w_if_rvalid, w_if_rdata); end
    // Read 0x010 granted this cycle; reset asserts before the next posedge.
    n_checks++; if (w_if_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_mid_gnt: got %b expected 1", w_if_gnt); end
    #1 w_rst_n = 1'b0;
    #1;
    n_checks++; if (w_if_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_async_clear: got %b expected 0", w_if_rvalid); end
    @(negedge w_clk); #1;
    n_checks++; if (w_if_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drop: got %b expected 0", w_if_rvalid); end
    w_if_req = 1'b0;
    w_rst_n = 1'b1;
    @(negedge w_clk); #1;
    n_checks++; if (dut.starve_cnt_r !== 4'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d expected 0", dut.starve_cnt_r); end
    n_checks++; if (w_if_rvalid !== 1'b0 || w_me_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalids: got %b%b expected 00", w_if_rvalid, w_me_rvalid); end
  endtask

  task automatic test_if_only();
    logic [DATA_W-1:0] exp_d [0:2];
    exp_d[0] = 32'h00000013; exp_d[1] = 32'h00100093; exp_d[2] = 32'h00200113;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        w_if_req = 1'b1; w_if_addr = 12'(i);
      end else begin
        w_if_req = 1'b0;
      end
      #1;
      if (i < 3) begin
        n_checks++; if (w_if_gnt !== 1'b1 || w_mem_addr !== 12'(i) || w_mem_we !== 1'b0) begin n_fail++; $display("FAIL if_gnt[%0d]: got gnt=%b addr=%h we=%b expected 1/%h/0", i, w_if_gnt, w_mem_addr, w_mem_we, i); end
      end
      if (i > 0) begin
        n_checks++; if (w_if_rvalid !== 1'b1 || w_if_rdata !== exp_d[i-1]) begin n_fail++; $display("FAIL if_data[%0d]: got %b/%h expected 1/%h", i-1, w_if_rvalid, w_if_rdata, exp_d[i-1]); end
      end
      @(negedge w_clk);
    end
    #1;
    n_checks++; if (w_if_rvalid !== 1'b0) begin n_fail++; $display("FAIL if_end_rvalid: got %b expected 0", w_if_rvalid); end
  endtask

  task automatic test_contention();
    @(negedge w_clk);
    w_if_req = 1'b1; w_if_addr = 12'h005;
    w_me_req = 1'b1; w_me_we = 1'b0; w_me_addr = 12'h100;
    #1;
    n_checks++; if (w_me_gnt !== 1'b1 || w_if_gnt !== 1'b0) begin n_fail++; $display("FAIL cont_gnt: got me=%b if=%b expected 1/0", w_me_gnt, w_if_gnt); end
    n_checks++; if (w_mem_addr !== 12'h100 || w_mem_we !== 1'b0) begin n_fail++; $display("FAIL cont_mux: got %h/%b expected 100/0", w_mem_addr, w_mem_we); end
    @(negedge w_clk);
    w_if_req = 1'b0; w_me_req = 1'b0;
    #1;
    n_checks++; if (w_me_rvalid !== 1'b1 || w_me_rdata !== 32'hDEADBEEF || w_if_rvalid !== 1'b0) begin n_fail++; $display("FAIL cont_data: got me_rv=%b %h if_rv=%b expected 1 deadbeef 0", w_me_rvalid, w_me_rdata, w_if_rvalid); end
    @(negedge w_clk);
  endtask

  task automatic test_starvation();
    logic prev_if;
    logic prev_me;
    logic exp_if;
    prev_if = 1'b0; prev_me = 1'b0;
    w_if_req = 1'b1; w_if_addr = 12'h001;
    w_me_req = 1'b1; w_me_we = 1'b0; w_me_addr = 12'h100;
    for (int k = 0; k < 12; k++) begin
      exp_if = ((k % 5) == 4);
      #1;
      n_checks++; if (w_if_gnt !== exp_if || w_me_gnt !== ~exp_if) begin n_fail++; $display("FAIL starve_gnt[%0d]: got if=%b me=%b expected %b/%b", k, w_if_gnt, w_me_gnt, exp_if, ~exp_if); end
      if (k > 0) begin
        n_checks++; if (w_if_rvalid !== prev_if || w_me_rvalid !== prev_me) begin n_fail++; $display("FAIL starve_rv[%0d]: got if=%b me=%b expected %b/%b", k, w_if_rvalid, w_me_rvalid, prev_if, prev_me); end
      end
      prev_if = exp_if; prev_me = ~exp_if;
      @(negedge w_clk);
    end
    w_if_req = 1'b0; w_me_req = 1'b0;
    @(negedge w_clk);
  endtask

  task automatic test_store_load();
    int we_cnt;
    we_cnt = 0;
    w_me_req = 1'b1; w_me_we = 1'b1; w_me_addr = 12'h200; w_me_wdata = 32'h12345678;
    #1;
    if (w_mem_we === 1'b1) we_cnt++;
    n_checks++; if (w_me_gnt !== 1'b1 || w_mem_din !== 32'h12345678 || w_mem_addr !== 12'h200) begin n_fail++; $display("FAIL st_mux: got gnt=%b din=%h addr=%h expected 1/12345678/200", w_me_gnt, w_mem_din, w_mem_addr); end
    @(negedge w_clk);
    w_me_we = 1'b0; w_me_wdata = 32'h0;
    #1;
    if (w_mem_we === 1'b1) we_cnt++;
    n_checks++; if (w_me_rvalid !== 1'b0) begin n_fail++; $display("FAIL st_no_rvalid: got %b expected 0", w_me_rvalid); end
    @(negedge w_clk);
    w_me_req = 1'b0;
    #1;
    if (w_mem_we === 1'b1) we_cnt++;
    n_checks++; if (w_me_rvalid !== 1'b1 || w_me_rdata !== 32'h12345678) begin n_fail++; $display("FAIL ld_data: got %b/%h expected 1/12345678", w_me_rvalid, w_me_rdata); end
    n_checks++; if (we_cnt !== 1) begin n_fail++; $display("FAIL st_we_cycles: got %0d expected 1", we_cnt); end
    @(negedge w_clk);
  endtask

  task automatic test_no_request();
    w_if_req = 1'b0; w_me_req = 1'b0; w_if_addr = 12'h3A5; w_me_addr = 12'h111; w_me_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (w_if_gnt !== 1'b0 || w_me_gnt !== 1'b0 || w_mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_gnt[%0d]: got if=%b me=%b we=%b expected 000", i, w_if_gnt, w_me_gnt, w_mem_we); end
      n_checks++; if (w_mem_addr !== 12'h3A5) begin n_fail++; $display("FAIL idle_addr[%0d]: got %h expected 3a5", i, w_mem_addr); end
      n_checks++; if (w_if_rvalid !== 1'b0 || w_me_rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_rv[%0d]: got %b%b expected 00", i, w_if_rvalid, w_me_rvalid); end
      n_checks++; if (dut.starve_cnt_r !== 4'd0) begin n_fail++; $display("FAIL idle_cnt[%0d]: got %0d expected 0", i, dut.starve_cnt_r); end
      @(negedge w_clk);
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 32'h0;
    mem[12'h000] = 32'h00000013;
    mem[12'h001] = 32'h00100093;
    mem[12'h002] = 32'h00200113;
    mem[12'h010] = 32'hCAFE0010;
    mem[12'h100] = 32'hDEADBEEF;
    w_rst_n = 1'b0;
    w_if_req = 1'b0; w_if_addr = 12'h000;
    w_me_req = 1'b0; w_me_we = 1'b0; w_me_addr = 12'h000; w_me_wdata = 32'h0;

    test_reset();
    test_if_only();
    test_contention();
    test_starvation();
    test_store_load();
    test_no_request();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
